// File: rtl/dac_burst_gen_if.sv
// Control-side bundle for dac_burst_gen: waveform write port, burst control,
// status and the eight channel sample outputs.
interface dac_burst_gen_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_drop;
    logic          trig;
    logic [AW-1:0] burst_len;
    logic [7:0]    ch_en;
    logic [7:0]    ch_inv;
    logic          busy;
    logic          done;
    logic          dout_vld;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic [DW-1:0] dout3;
    logic [DW-1:0] dout4;
    logic [DW-1:0] dout5;
    logic [DW-1:0] dout6;
    logic [DW-1:0] dout7;

    modport master (
        output wr_en, wr_addr, wr_data, trig, burst_len, ch_en, ch_inv,
        input  wr_drop, busy, done, dout_vld,
        input  dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, trig, burst_len, ch_en, ch_inv,
        output wr_drop, busy, done, dout_vld,
        output dout0, dout1, dout2, dout3, dout4, dout5, dout6, dout7
    );
endinterface

// File: rtl/dac_burst_gen.sv
// Waveform burst generator: one stored waveform is played on trigger to eight
// DAC channels, each with its own enable and saturating polarity inversion.
// Pipeline: rd_addr (PLAY) -> registered RAM read -> registered channel outputs.
module dac_burst_gen #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input logic           clk,
    input logic           rst,
    dac_burst_gen_if.slave bus
);
    localparam int NCH = 8;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   len_q;
    logic [NCH-1:0]  en_q;
    logic [NCH-1:0]  inv_q;
    logic            drain_cnt;
    logic            busy_q;
    logic            done_q;
    logic            start;
    logic            done_nxt;

    logic [DW-1:0]   mem [2**AW];
    logic [DW-1:0]   ram_q;
    logic            rd_vld;
    logic            vld_q;
    logic            wr_drop_q;
    logic [DW-1:0]   dout_q [NCH];

    // Two's complement negate that clamps the most negative code to max positive.
    function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] s);
        if (s == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        return ~s + DW'(1);
    endfunction

    // Next-state decode: start a burst from IDLE, leave PLAY on the last
    // address, spend two flush cycles in DRAIN and flag done on the second.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        start     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // busy_q covers the done cycle, so a trig there is ignored.
                if (bus.trig && !busy_q) begin
                    start     = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (rd_addr == len_q)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, read address counter, latched burst configuration and
    // the busy/done status flags.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout clocked logic, so every
        // register samples values from before the edge regardless of order.
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= '0;
            len_q     <= '0;
            en_q      <= '0;
            inv_q     <= '0;
            drain_cnt <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_q    <= done_nxt;
            // busy stays up through the done cycle and drops the cycle after.
            busy_q    <= (state_nxt != IDLE) || done_nxt;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (start) begin
                len_q   <= bus.burst_len;
                en_q    <= bus.ch_en;
                inv_q   <= bus.ch_inv;
                rd_addr <= '0;
            end else if (state == PLAY && rd_addr != len_q) begin
                rd_addr <= rd_addr + AW'(1);
            end
        end
    end

    // Waveform RAM: writes accepted only while idle, registered read port.
    always_ff @(posedge clk) begin
        // NOTE: the array and its read register are deliberately not reset;
        // stored waveforms survive reset and ram_q is qualified by rd_vld.
        if (bus.wr_en && !busy_q)
            mem[bus.wr_addr] <= bus.wr_data;
        ram_q <= mem[rd_addr];
    end

    // Output stage: valid tracking, write-drop pulse and per-channel
    // enable/inversion of the sample read from RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld    <= 1'b0;
            vld_q     <= 1'b0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < NCH; i++)
                dout_q[i] <= '0;
        end else begin
            rd_vld    <= (state == PLAY);
            vld_q     <= rd_vld;
            wr_drop_q <= bus.wr_en && busy_q;
            for (int i = 0; i < NCH; i++) begin
                if (rd_vld && en_q[i])
                    dout_q[i] <= inv_q[i] ? sat_neg(ram_q) : ram_q;
                else
                    dout_q[i] <= '0;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.dout_vld = vld_q;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.dout0    = dout_q[0];
    assign bus.dout1    = dout_q[1];
    assign bus.dout2    = dout_q[2];
    assign bus.dout3    = dout_q[3];
    assign bus.dout4    = dout_q[4];
    assign bus.dout5    = dout_q[5];
    assign bus.dout6    = dout_q[6];
    assign bus.dout7    = dout_q[7];
endmodule

// File: tb/tb_dac_burst_gen.sv
// Self-checking bench for dac_burst_gen. A shadow RAM model produces the
// expected per-channel frames, queued at trigger time and compared when
// dout_vld is seen; burst timing is checked against the trigger edge.
module tb_dac_burst_gen;
    localparam int DW = 16;
    localparam int AW = 8;

    typedef logic [7:0][DW-1:0] frame_t;

    typedef struct {
        int          len;
        logic [7:0]  en;
        logic [7:0]  inv;
        logic [15:0] first0;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_model [2**AW];
    frame_t        sb_q [$];

    int          busy_first, busy_last, first_vld, last_vld;
    int          vld_cnt, done_cnt, done_cyc, drop_cnt;
    logic [15:0] first_d0;

    vec_t vecs [5];

    dac_burst_gen_if #(.DW(DW), .AW(AW)) bus ();

    dac_burst_gen #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    function automatic logic [DW-1:0] neg_clamp(input logic [DW-1:0] s);
        if (s == 16'h8000)
            return 16'h7FFF;
        return 16'(0 - int'(s));
    endfunction

    function automatic frame_t model_frame(input int addr, input logic [7:0] en, input logic [7:0] inv);
        frame_t f;
        for (int ch = 0; ch < 8; ch++) begin
            if (!en[ch])
                f[ch] = '0;
            else if (inv[ch])
                f[ch] = neg_clamp(mem_model[addr]);
            else
                f[ch] = mem_model[addr];
        end
        return f;
    endfunction

    // Output monitor: scoreboard compare on valid samples, zero outputs
    // otherwise, and timing bookkeeping in bench cycle numbers.
    always @(negedge clk) begin
        automatic int     now = cyc + 1;
        automatic frame_t act;
        automatic frame_t exp;
        act = {bus.dout7, bus.dout6, bus.dout5, bus.dout4,
               bus.dout3, bus.dout2, bus.dout1, bus.dout0};
        if (bus.busy === 1'b1) begin
            if (busy_first == 0) busy_first = now;
            busy_last = now;
        end
        if (bus.wr_drop === 1'b1) drop_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = now;
            check("done_vld_excl", {31'b0, bus.dout_vld}, 32'd0);
        end
        if (bus.dout_vld === 1'b1) begin
            if (first_vld == 0) begin
                first_vld = now;
                first_d0  = bus.dout0;
            end
            last_vld = now;
            vld_cnt++;
            check("sb_nonempty", {31'b0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                for (int ch = 0; ch < 8; ch++)
                    check($sformatf("dout%0d", ch), {16'b0, act[ch]}, {16'b0, exp[ch]});
            end
        end else begin
            check("idle_zero", {31'b0, |act}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        busy_first = 0; busy_last = 0; first_vld = 0; last_vld = 0;
        vld_cnt = 0; done_cnt = 0; done_cyc = 0; drop_cnt = 0; first_d0 = '0;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        if (bus.busy == 1'b0) mem_model[addr] = data;
        step();
        bus.wr_en = 1'b0;
    endtask

    // Drive trig for one edge; t returns the bench cycle number of that edge.
    // Config inputs are scrambled afterwards to show they were latched.
    task automatic start_burst(input int len, input logic [7:0] en, input logic [7:0] inv, output int t);
        for (int k = 0; k <= len; k++)
            sb_q.push_back(model_frame(k, en, inv));
        clear_stats();
        bus.burst_len = AW'(len);
        bus.ch_en     = en;
        bus.ch_inv    = inv;
        bus.trig      = 1'b1;
        step();
        t = cyc;
        bus.trig      = 1'b0;
        bus.burst_len = 8'($urandom);
        bus.ch_en     = 8'($urandom);
        bus.ch_inv    = 8'($urandom);
    endtask

    // Wait (bounded) for busy to drop, then check the burst timeline.
    task automatic finish_burst(input string name, input int t, input int len);
        int budget = 0;
        while (bus.busy !== 1'b0 && budget < 400) begin
            step();
            budget++;
        end
        check({name, "_timeout"}, {31'b0, budget < 400}, 32'd1);
        check({name, "_busy_fall"}, cyc + 1, t + 5 + len);
        check({name, "_busy_first"}, busy_first, t + 1);
        check({name, "_busy_last"}, busy_last, t + 4 + len);
        check({name, "_first_vld"}, first_vld, t + 3);
        check({name, "_last_vld"}, last_vld, t + 3 + len);
        check({name, "_vld_cnt"}, vld_cnt, len + 1);
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_done_cyc"}, done_cyc, t + 4 + len);
        check({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        int t;

        vecs[0] = '{len: 3, en: 8'hFF, inv: 8'h00, first0: 16'h0001};
        vecs[1] = '{len: 3, en: 8'h5F, inv: 8'h0F, first0: 16'hFFFF};
        vecs[2] = '{len: 4, en: 8'hFF, inv: 8'hFF, first0: 16'hFFFF};
        vecs[3] = '{len: 1, en: 8'h00, inv: 8'hFF, first0: 16'h0000};
        vecs[4] = '{len: 7, en: 8'hA5, inv: 8'h3C, first0: 16'h0001};

        rst           = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.trig      = 1'b0;
        bus.burst_len = '0;
        bus.ch_en     = '0;
        bus.ch_inv    = '0;
        clear_stats();
        for (int i = 0; i < 3; i++) step();

        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_vld", {31'b0, bus.dout_vld}, 32'd0);
        check("rst_wr_drop", {31'b0, bus.wr_drop}, 32'd0);
        check("rst_dout0", {16'b0, bus.dout0}, 32'd0);
        check("rst_dout7", {16'b0, bus.dout7}, 32'd0);
        rst = 1'b0;
        step();

        // Waveform image: boundary codes first, then a zero and a ramp.
        wr(0, 16'h0001);
        wr(1, 16'h0002);
        wr(2, 16'h7FFF);
        wr(3, 16'h8000);
        wr(4, 16'h0000);
        for (int a = 5; a < 16; a++)
            wr(a, DW'(a * 16'h0111 + 3));

        // Table of back-to-back bursts; each starts in the first cycle busy is 0.
        for (int v = 0; v < 5; v++) begin
            start_burst(vecs[v].len, vecs[v].en, vecs[v].inv, t);
            finish_burst($sformatf("vec%0d", v), t, vecs[v].len);
            check($sformatf("vec%0d_first_d0", v), {16'b0, first_d0}, {16'b0, vecs[v].first0});
        end

        // Single-sample burst with a write to address 0 on the trigger edge.
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = 16'h1234;
        mem_model[0] = 16'h1234;
        start_burst(0, 8'hFF, 8'h00, t);
        bus.wr_en = 1'b0;
        finish_burst("len0", t, 0);
        check("len0_first_d0", {16'b0, first_d0}, 32'h1234);

        // Mid-burst trig, burst_len change and dropped write.
        start_burst(9, 8'hFF, 8'h00, t);
        for (int i = 0; i < 4; i++) step();
        bus.trig      = 1'b1;
        bus.burst_len = 8'd1;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 8'd2;
        bus.wr_data   = 16'hDEAD;
        step();
        check("wr_drop_pulse", {31'b0, bus.wr_drop}, 32'd1);
        bus.trig  = 1'b0;
        bus.wr_en = 1'b0;
        finish_burst("midtrig", t, 9);
        check("midtrig_drop_cnt", drop_cnt, 1);
        step();
        check("no_requeue", {31'b0, bus.busy}, 32'd0);
        start_burst(3, 8'hFF, 8'h00, t);
        finish_burst("ram_kept", t, 3);

        // Reset in the middle of a burst.
        start_burst(9, 8'hFF, 8'h00, t);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        check("abort_vld", {31'b0, bus.dout_vld}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_dout0", {16'b0, bus.dout0}, 32'd0);
        check("abort_dout3", {16'b0, bus.dout3}, 32'd0);
        rst = 1'b0;
        check("abort_vld_cnt", vld_cnt, 3);
        sb_q.delete();
        for (int i = 0; i < 6; i++) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", {31'b0, bus.busy}, 32'd0);
        start_burst(3, 8'hFF, 8'h00, t);
        finish_burst("after_abort", t, 3);
        check("after_abort_first_d0", {16'b0, first_d0}, {16'b0, mem_model[0]});

        // Full-depth burst over a ramp: no wrap.
        for (int a = 0; a < 256; a++)
            wr(a, DW'(a));
        start_burst(255, 8'hFF, 8'h00, t);
        finish_burst("full", t, 255);
        check("full_last_cyc", done_cyc, t + 259);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dac_burst_gen.md
Name: dac_burst_gen

Overview:
- Transmit-side counterpart of the 8-channel receive sample path: plays one stored waveform burst to 8 DAC channel outputs on a trigger.
- A single 16-bit waveform RAM is loaded through a simple write port.
- On each trigger, every channel receives the same sample stream, with per-channel enable and per-channel polarity inversion.
- Sits between the control/register block and the DAC interface, in the same clock domain as the receive-side sample processing.

Parameters:
- DW, 16, sample width in bits (two's complement).
- AW, 8, waveform RAM address width (depth 2^AW).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- wr_en  in  1  waveform RAM write strobe
- wr_addr  in  AW  waveform RAM write address
- wr_data  in  DW  waveform RAM write data
- wr_drop  out  1  one-cycle pulse: write rejected because busy=1
- trig  in  1  burst start request (level sampled each cycle)
- burst_len  in  AW  burst length minus one (samples played = burst_len+1)
- ch_en  in  8  per-channel enable
- ch_inv  in  8  per-channel polarity invert
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after the last sample
- dout_vld  out  1  dout0..dout7 carry valid samples
- dout0..dout7  out  DW each  channel sample outputs, registered

Behaviour:
- Reset (synchronous, active-high): state IDLE; rd_addr=0; busy, done, dout_vld, wr_drop all 0; dout0..dout7 all 0.
- Reset asserted mid-burst aborts the burst immediately: no done pulse, and outputs return to their reset values on the next edge.
- RAM contents are not cleared by reset.
- RAM: AW x DW, one write port and one registered read port (1-cycle read latency).
  - Write when wr_en=1 and busy=0.
  - wr_en=1 while busy=1 drops the write and pulses wr_drop the next cycle.
- FSM states: IDLE, PLAY, DRAIN.
  - IDLE: on trig=1 at edge T, latch burst_len, ch_en and ch_inv into len_q, en_q and inv_q; set rd_addr=0; go to PLAY. busy=1 from T+1.
  - PLAY: issue rd_addr each cycle. At rd_addr==len_q, go to DRAIN; otherwise increment rd_addr.
  - DRAIN: 2 cycles to flush the RAM and output pipeline, then return to IDLE. done=1 in the last DRAIN cycle. busy is deasserted in the cycle after done.
- Latency:
  - Sample k (k=0..L, with L=len_q) appears on dout with dout_vld=1 at cycle T+3+k.
  - dout_vld is high for exactly L+1 consecutive cycles.
  - done=1 at cycle T+4+L. busy is high from T+1 through T+4+L.
- trig while busy=1 is ignored. It is not queued.
- A trig in the cycle busy returns to 0 is accepted.
- Changes to burst_len, ch_en or ch_inv mid-burst have no effect, because they are latched at start.
- burst_len=0 plays exactly 1 sample.
- burst_len=2^AW-1 plays the full RAM with no wrap.
- Per-channel output function, registered, for sample s:
  - dout_vld=0: dout=0.
  - en_q[i]=0: dout_i=0.
  - inv_q[i]=0: dout_i=s.
  - inv_q[i]=1: dout_i=-s, saturating, so 0x8000 maps to 0x7FFF and 0x0000 stays 0x0000.
- Simultaneous wr_en and trig in IDLE: the write completes (busy is still 0 at that edge), and the burst starts.
- A write to address 0 at edge T is visible to the read at T+1 (read-after-write on separate cycles).
- done and dout_vld are never high in the same cycle.

Test Plan:
- Load RAM[0..3]=0x0001,0x0002,0x7FFF,0x8000; burst_len=3, ch_en=0xFF, ch_inv=0x00; pulse trig at T -> dout0..7 = 0x0001,0x0002,0x7FFF,0x8000 at T+3..T+6 with dout_vld=1; done=1 at T+7; busy low at T+8.
- Same RAM, ch_inv=0x0F, ch_en=0x5F -> dout0..3 = 0xFFFF,0xFFFE,0x8001,0x7FFF; dout4 and dout6 match RAM; dout5 and dout7 are 0 throughout.
- burst_len=0, RAM[0]=0x1234 -> one dout_vld cycle at T+3 with dout=0x1234; done at T+4.
- During a burst with burst_len=9: re-pulse trig at T+5 and change burst_len to 1 -> still exactly 10 valid samples and one done; wr_en at T+5 gives wr_drop=1 at T+6 and RAM unchanged (verified by a follow-up burst).
- Assert rst at T+5 of a 10-sample burst -> at T+6, dout=0, dout_vld=0, busy=0, and no done; a new trig is then accepted and plays from address 0.
- burst_len=255 after loading RAM[a]=a -> 256 samples, 0x0000..0x00FF in order, no wrap; done at T+259.
